// File: rtl/branch_predictor.sv
// Fetch-side 2-bit saturating-counter direction predictor with execute-stage training,
// registered mispredict/flush pulse and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int IDX_W  = 4,
    parameter int PC_W   = 16,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [2:0]        ex_type,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    output logic              mispredict,
    output logic              flush,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mp_count
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [1:0]        table_q [ENTRIES];
    logic [1:0]        table_d [ENTRIES];
    logic              mispredict_q, mispredict_d;
    logic [STAT_W-1:0] br_count_q, br_count_d;
    logic [STAT_W-1:0] mp_count_q, mp_count_d;

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              cond;
    logic              wrong;
    logic              unused_pc_bits;

    // Bit 0 of the PC is dropped: instructions are 2 bytes wide.
    assign if_idx = if_pc[IDX_W:1];
    assign ex_idx = ex_pc[IDX_W:1];
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+1], if_pc[0], ex_pc[PC_W-1:IDX_W+1], ex_pc[0]};

    assign cond  = ex_valid & (ex_type < 3'b100);
    assign wrong = cond & (ex_taken != ex_pred_taken);

    // Reads the registered table, so a same-index update shows up one cycle later.
    assign pred_taken = table_q[if_idx][1];

    always_comb begin
        table_d      = table_q;
        mispredict_d = wrong;
        br_count_d   = br_count_q;
        mp_count_d   = mp_count_q;
        if (cond) begin
            if (ex_taken) begin
                if (table_q[ex_idx] != 2'b11) table_d[ex_idx] = table_q[ex_idx] + 2'b01;
            end else begin
                if (table_q[ex_idx] != 2'b00) table_d[ex_idx] = table_q[ex_idx] - 2'b01;
            end
            if (br_count_q != '1) br_count_d = br_count_q + STAT_W'(1);
        end
        if (wrong && (mp_count_q != '1)) mp_count_d = mp_count_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
            mispredict_q <= 1'b0;
            br_count_q   <= '0;
            mp_count_q   <= '0;
        end else begin
            table_q      <= table_d;
            mispredict_q <= mispredict_d;
            br_count_q   <= br_count_d;
            mp_count_q   <= mp_count_d;
        end
    end

    assign mispredict = mispredict_q;
    assign flush      = mispredict_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;
endmodule
